// File: rtl/dlc_pkg.sv
// Shared definitions for the DLC trim serial path: FSM states and the trim
// frame layout used by both the transmitter and the receiver-side loader.
package dlc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    LATCH = ST_LATCH
  } state_t;

  localparam int TRIM_W     = 4;
  localparam int TRIM_P_MSB = 7;
  localparam int TRIM_N_MSB = 3;

  function automatic logic [2*TRIM_W-1:0] pack_trim(input logic [TRIM_W-1:0] trim_p,
                                                    input logic [TRIM_W-1:0] trim_n);
    logic [2*TRIM_W-1:0] w;
    w = '0;
    w[TRIM_P_MSB -: TRIM_W] = trim_p;
    w[TRIM_N_MSB -: TRIM_W] = trim_n;
    return w;
  endfunction

endpackage

// File: rtl/dlc_cfg_tick.sv
// Half-period timer: while enabled, tick is high for one cycle every HALF
// cycles. The count restarts on every tick and whenever clear is high.
module dlc_cfg_tick #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  generate
    if (HALF == 1) begin : g_every
      // Every enabled cycle is a phase boundary; the count is never looked at.
      assign tick = en;
    end else begin : g_count
      assign tick = en && (cnt == CW'(HALF - 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dlc_cfg_tx.sv
// DLC trim serial transmitter: shifts a parallel frame MSB-first on sdo with a
// divided sclk, then strobes latch for one half-period so the receiver commits.
module dlc_cfg_tx
  import dlc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HALF  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdo,
  output logic             latch,
  output state_t           state_dbg
);

  localparam int BW = $clog2(WIDTH + 1);

  // Handshake: start is a request taken only in a cycle where busy is low
  // (IDLE, including the done cycle); data is captured in that same cycle and
  // a request seen while busy is high is dropped, never queued.

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic [WIDTH-1:0] shifted;

  assign shifted   = shreg << 1;
  assign state_dbg = state;

  dlc_cfg_tick #(.HALF(HALF)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .clear (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      latch   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= data;
            sdo     <= data[WIDTH-1];
            bit_cnt <= '0;
            busy    <= 1'b1;
            sclk    <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BW'(WIDTH - 1)) begin
                // Last bit stays on sdo through the latch window.
                bit_cnt <= '0;
                latch   <= 1'b1;
                state   <= LATCH;
              end else begin
                shreg   <= shifted;
                sdo     <= shifted[WIDTH-1];
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
        end
        LATCH: begin
          if (tick) begin
            latch <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            sdo   <= 1'b0;
            shreg <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sclk  <= 1'b0;
          sdo   <= 1'b0;
          latch <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlc_cfg_tx.sv
// Bench for dlc_cfg_tx: a HALF=4 and a HALF=1 instance checked every cycle
// against a timeline model, plus a serial receiver model and directed frames.
module tb_dlc_cfg_tx;
  import dlc_pkg::*;

  localparam int W  = 8;
  localparam int H0 = 4;
  localparam int H1 = 1;

  typedef struct packed {
    logic busy;
    logic done;
    logic sclk;
    logic sdo;
    logic latch;
  } outs_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start0 = 1'b0, start1 = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         busy0, done0, sclk0, sdo0, latch0;
  logic         busy1, done1, sclk1, sdo1, latch1;
  state_t       st0, st1;

  dlc_cfg_tx #(.WIDTH(W), .HALF(H0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .data(data0),
    .busy(busy0), .done(done0), .sclk(sclk0), .sdo(sdo0), .latch(latch0),
    .state_dbg(st0)
  );

  dlc_cfg_tx #(.WIDTH(W), .HALF(H1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data(data1),
    .busy(busy1), .done(done1), .sclk(sclk1), .sdo(sdo1), .latch(latch1),
    .state_dbg(st1)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- frame timeline model ----------------
  // t is the cycle offset from acceptance (t=1 first SHIFT cycle), -1 when idle.
  function automatic outs_t model_out(input int t, input logic [W-1:0] d, input int h);
    outs_t e;
    int k, ph;
    e = '0;
    if (t >= 1 && t <= 2*h*W) begin
      k      = (t - 1) / (2*h);
      ph     = (t - 1) % (2*h);
      e.busy = 1'b1;
      e.sclk = (ph >= h);
      e.sdo  = d[W-1-k];
    end else if (t > 2*h*W && t <= 2*h*W + h) begin
      e.busy  = 1'b1;
      e.latch = 1'b1;
      e.sdo   = d[0];
    end else if (t == 2*h*W + h + 1) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  localparam int DT0 = 2*H0*W + H0 + 1;
  localparam int DT1 = 2*H1*W + H1 + 1;

  int           t0 = -1, t1 = -1;
  logic [W-1:0] md0 = '0, md1 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t0 = -1;
      t1 = -1;
    end else begin
      if ((t0 < 0 || t0 == DT0) && start0) begin
        t0 = 1; md0 = data0;
      end else if (t0 >= 0) begin
        t0 = (t0 == DT0) ? -1 : t0 + 1;
      end
      if ((t1 < 0 || t1 == DT1) && start1) begin
        t1 = 1; md1 = data1;
      end else if (t1 >= 0) begin
        t1 = (t1 == DT1) ? -1 : t1 + 1;
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("dut0_outs", {busy0, done0, sclk0, sdo0, latch0}, model_out(t0, md0, H0));
      check("dut1_outs", {busy1, done1, sclk1, sdo1, latch1}, model_out(t1, md1, H1));
    end
  end

  // ---------------- receiver model + scoreboard ----------------
  logic [W-1:0] rx_sh0 = '0, rx_lat0 = '0, rx_sh1 = '0, rx_lat1 = '0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           latch_cnt0 = 0, latch_cnt1 = 0;

  always @(posedge sclk0) rx_sh0 = {rx_sh0[W-2:0], sdo0};
  always @(posedge sclk1) rx_sh1 = {rx_sh1[W-2:0], sdo1};

  always @(posedge latch0) begin
    rx_lat0 = rx_sh0;
    latch_cnt0++;
    if (exp_q0.size() == 0) check("rx0_unexpected_latch", 32'(rx_sh0), 32'hFFFF_FFFF);
    else check("rx0_word", 32'(rx_sh0), 32'(exp_q0.pop_front()));
  end

  always @(posedge latch1) begin
    rx_lat1 = rx_sh1;
    latch_cnt1++;
    if (exp_q1.size() == 0) check("rx1_unexpected_latch", 32'(rx_sh1), 32'hFFFF_FFFF);
    else check("rx1_word", 32'(rx_sh1), 32'(exp_q1.pop_front()));
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge (cycle 1).
  task automatic send0(input logic [W-1:0] d);
    start0 = 1'b1; data0 = d;
    @(posedge clk); #1;
    start0 = 1'b0; data0 = W'($urandom);
  endtask

  task automatic send1(input logic [W-1:0] d);
    start1 = 1'b1; data1 = d;
    @(posedge clk); #1;
    start1 = 1'b0; data1 = W'($urandom);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns the cycle (counting the current one as cyc) at which done0 is seen.
  task automatic wait_done0(input int cyc, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (done0) begin at = cyc + i; break; end
      @(posedge clk); #1;
    end
    if (at < 0) check("done0_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int first_latch, last_latch, done_cyc, busy_first, busy_last;
    int rise_first, rise_last, rise_n, lc, at;
    logic prev_sclk;

    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;

    // 1. reset / idle
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_sclk",  32'(sclk0),  32'd0);
    check("rst_sdo",   32'(sdo0),   32'd0);
    check("rst_latch", 32'(latch0), 32'd0);
    check("rst_done",  32'(done0),  32'd0);
    check("rst_state", 32'(st0),    32'(IDLE));
    rise_n = 0; prev_sclk = sclk0;
    for (int i = 0; i < 20; i++) begin
      if (sclk0 && !prev_sclk) rise_n++;
      prev_sclk = sclk0;
      step(1);
    end
    check("idle_no_sclk", 32'(rise_n), 32'd0);

    // 5. reset mid-frame (receiver still holds 8'h00)
    send0(8'hF0);
    step(29);                       // now in cycle 30
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy0),  32'd0);
    check("abort_sdo",   32'(sdo0),   32'd0);
    check("abort_sclk",  32'(sclk0),  32'd0);
    check("abort_latch", 32'(latch0), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_state", 32'(st0), 32'(IDLE));
    step(100);
    check("abort_no_latch", 32'(latch_cnt0), 32'd0);
    check("abort_rx_hold",  32'(rx_lat0),    32'h00);

    // 2. single frame 8'hA5 with literal timing
    exp_q0.push_back(8'hA5);
    send0(8'hA5);
    first_latch = -1; last_latch = -1; done_cyc = -1; busy_first = -1; busy_last = -1;
    rise_first = -1; rise_last = -1; rise_n = 0; prev_sclk = 1'b0;
    for (int cyc = 1; cyc <= 72; cyc++) begin
      if (sclk0 && !prev_sclk) begin
        if (rise_first < 0) rise_first = cyc;
        rise_last = cyc; rise_n++;
      end
      prev_sclk = sclk0;
      if (latch0) begin if (first_latch < 0) first_latch = cyc; last_latch = cyc; end
      if (busy0)  begin if (busy_first < 0) busy_first = cyc; busy_last = cyc; end
      if (done0 && done_cyc < 0) done_cyc = cyc;
      step(1);
    end
    check("a5_rise_first",  32'(rise_first),  32'd5);
    check("a5_rise_last",   32'(rise_last),   32'd61);
    check("a5_rise_count",  32'(rise_n),      32'd8);
    check("a5_latch_first", 32'(first_latch), 32'd65);
    check("a5_latch_last",  32'(last_latch),  32'd68);
    check("a5_done_cycle",  32'(done_cyc),    32'd69);
    check("a5_busy_first",  32'(busy_first),  32'd1);
    check("a5_busy_last",   32'(busy_last),   32'd68);
    check("a5_rx",          32'(rx_lat0),     32'hA5);

    // 3. start while busy is ignored
    exp_q0.push_back(8'h3C);
    lc = latch_cnt0;
    send0(8'h3C);
    step(19);                       // cycle 20
    start0 = 1'b1; data0 = 8'hFF;
    step(1);
    start0 = 1'b0; data0 = 8'h00;
    wait_done0(21, at);
    check("busy_ign_done", 32'(at), 32'd69);
    step(100);
    check("busy_ign_rx",      32'(rx_lat0),         32'h3C);
    check("busy_ign_latches", 32'(latch_cnt0 - lc), 32'd1);

    // 4. back-to-back: second start in the done cycle
    exp_q0.push_back(8'h12);
    exp_q0.push_back(8'h87);
    lc = latch_cnt0;
    send0(8'h12);
    wait_done0(1, at);
    check("b2b_first_done", 32'(at), 32'd69);
    send0(8'h87);
    rise_first = -1; prev_sclk = sclk0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (sclk0 && !prev_sclk) begin rise_first = cyc; break; end
      prev_sclk = sclk0;
      step(1);
    end
    check("b2b_second_rise", 32'(rise_first), 32'(1 + H0));
    wait_done0(rise_first, at);
    step(2);
    check("b2b_rx",       32'(rx_lat0),         32'h87);
    check("b2b_latches",  32'(latch_cnt0 - lc), 32'd2);

    // 6. HALF=1 instance
    exp_q1.push_back(8'h01);
    send1(8'h01);
    done_cyc = -1; rise_n = 0; prev_sclk = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (sclk1 && !prev_sclk) rise_n++;
      prev_sclk = sclk1;
      if (done1 && done_cyc < 0) done_cyc = cyc;
      step(1);
    end
    check("h1_done_cycle", 32'(done_cyc), 32'd18);
    check("h1_rises",      32'(rise_n),   32'd8);
    check("h1_rx",         32'(rx_lat1),  32'h01);

    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dlc_cfg_tx.md
Name: dlc_cfg_tx

Overview:
Serial configuration transmitter for the DLC trim loader. It takes a parallel trim word (trim_p in the upper nibble, trim_n in the lower nibble) and shifts it MSB-first on sdo with a divided serial clock. It then pulses latch so the DLC's receiving shift register commits the word. It sits in the digital control domain and drives the DLC's sdi/latch pins and its serial clock.

Parameters:
WIDTH, 8, number of bits per frame (trim_p[3:0] in bits 7:4, trim_n[3:0] in bits 3:0); legal range >=1
HALF, 4, clk cycles per sclk half-period; legal range >=1

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request to transmit data; honoured only when busy=0
data  input  WIDTH  frame to send; sampled in the cycle start is accepted
busy  output  1  high while a frame is in flight
done  output  1  one-cycle pulse when the frame has been latched
sclk  output  1  serial clock to the receiver; the receiver samples sdo on the rising edge
sdo  output  1  serial data, MSB first; changes only while sclk is low
latch  output  1  commit strobe to the receiver; high for HALF cycles after the last bit

Behaviour:
- All outputs are registered; no combinational paths from inputs to outputs.
- Reset (rst_n=0, asynchronous): state=IDLE, sclk=0, sdo=0, latch=0, busy=0, done=0, shift register=0, counters=0.
- States are IDLE, SHIFT, LATCH.
- IDLE:
  - start=1 at cycle 0: capture data into shreg, set bit_cnt=0 and half-period counter=0.
  - Go to SHIFT; busy=1 and sdo=data[WIDTH-1] from cycle 1.
  - start while busy=1 is ignored, with no queueing.
- SHIFT:
  - Each bit occupies 2*HALF cycles: sclk=0 for HALF cycles, then sclk=1 for HALF cycles.
  - At the end of the high phase, sclk returns to 0. In that same edge, shreg shifts left, sdo takes the next bit, and bit_cnt increments.
  - sdo is therefore stable for HALF cycles on both sides of each sclk rising edge.
  - After bit WIDTH-1 completes its high phase: go to LATCH with sclk=0 and latch=1. sdo holds the last bit.
- LATCH:
  - latch=1 for exactly HALF cycles; sclk stays 0.
  - Then go to IDLE with latch=0, busy=0, done=1 for one cycle, sdo=0.
- Latency: with start accepted at cycle 0, the first sclk rising edge is at cycle 1+HALF. latch is high for cycles 2*HALF*WIDTH+1 through 2*HALF*WIDTH+HALF. done=1 at cycle 2*HALF*WIDTH+HALF+1. Defaults give 64+4+1 = cycle 69.
- Back-to-back: start=1 in the done cycle is accepted, because busy=0 in that cycle. The next frame's SHIFT begins on the following cycle, and there is no gap beyond the one IDLE cycle.
- Counters:
  - bit_cnt width is clog2(WIDTH+1).
  - half counter width is clog2(HALF); for HALF=1, use a 1-bit counter that is never compared.
  - No wrap is permitted; each counter is cleared on every phase or state change.
- Reset mid-frame: the frame aborts immediately and latch is never asserted. The receiver therefore keeps its previously latched trim. After reset release, the block sits in IDLE.
- Changes to data after acceptance have no effect on the frame in flight.
- HALF=1: sclk toggles every clk cycle, and the protocol rules above still hold.

Decomposition:
- A shared package dlc_pkg holds:
  - the state enum (IDLE, SHIFT, LATCH) as localparams;
  - TRIM_W=4;
  - the frame layout constants TRIM_P_MSB=7 and TRIM_N_MSB=3, shared with the receiver-side loader.
- One sub-module, dlc_cfg_tick, is the half-period counter. It takes enable and clear, and outputs a one-cycle tick every HALF cycles. The parent uses the tick to advance the phase and bit counter.

Test Plan:
1. Reset check: hold rst_n=0, then release → sclk, sdo, latch, busy and done are all 0; no sclk edges occur while idle.
2. Single frame: WIDTH=8, HALF=4, data=8'hA5, start at cycle 0 →
   - the receiver model samples 1,0,1,0,0,1,0,1 on the sclk rising edges at cycles 5, 13, …, 61;
   - latch is high for cycles 65–68; done is high at cycle 69; busy is high for cycles 1–68.
3. Start while busy: data=8'h3C started at cycle 0, then start=1 with data=8'hFF at cycle 20 → the second request is ignored and the receiver latches 8'h3C.
4. Back-to-back: frame 8'h12, then start with 8'h87 in the done cycle → the second frame's first rising edge is 1+HALF cycles later. The receiver latches 8'h12 and then 8'h87, with no dropped bits.
5. Reset mid-frame: send 8'hF0 and pull rst_n low at cycle 30 → outputs are 0 asynchronously, latch is never asserted, and the receiver still holds its prior value (8'h00).
6. HALF=1, WIDTH=8, data=8'h01 → sclk toggles every cycle, the receiver latches 8'h01, and done is asserted at cycle 18.
